// File: rtl/adder_tree_operand_loader.sv
// Collects operands into an 8-slot bank and issues full (or flushed, zero-padded)
// groups through a registered output bank that feeds an 8-input adder tree.
module adder_tree_operand_loader #(
  parameter int ADDER_WIDTH   = 7,
  parameter int GRP_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDER_WIDTH-1:0]   in_data,
  input  logic                     in_flush,
  output logic [ADDER_WIDTH-1:0]   isum0_0_0_0,
  output logic [ADDER_WIDTH-1:0]   isum0_0_0_1,
  output logic [ADDER_WIDTH-1:0]   isum0_0_1_0,
  output logic [ADDER_WIDTH-1:0]   isum0_0_1_1,
  output logic [ADDER_WIDTH-1:0]   isum0_1_0_0,
  output logic [ADDER_WIDTH-1:0]   isum0_1_0_1,
  output logic [ADDER_WIDTH-1:0]   isum0_1_1_0,
  output logic [ADDER_WIDTH-1:0]   isum0_1_1_1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [GRP_CNT_WIDTH-1:0] grp_count
);

  logic [ADDER_WIDTH-1:0]   coll_q  [8];
  logic [ADDER_WIDTH-1:0]   coll_d  [8];
  logic [ADDER_WIDTH-1:0]   obank_q [8];
  logic [ADDER_WIDTH-1:0]   obank_d [8];
  logic [2:0]               idx_q, idx_d;
  logic                     ov_q, ov_d;
  logic [GRP_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       stall;
  logic       accept;
  logic       issue;
  logic [3:0] fill;

  // Stall only when an issue this cycle would overwrite an unconsumed output bank.
  assign stall    = ov_q & ~out_ready & ((idx_q == 3'd7) | in_flush);
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;
  assign issue    = ~stall & ((accept & (idx_q == 3'd7)) |
                              (in_flush & ((idx_q != 3'd0) | accept)));
  assign fill     = {1'b0, idx_q} + {3'b000, accept};

  always_comb begin
    coll_d  = coll_q;
    obank_d = obank_q;
    idx_d   = idx_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    if (accept) coll_d[idx_q] = in_data;
    if (issue) begin
      // Slots at or beyond the fill point are forced to zero in the issued group.
      for (int i = 0; i < 8; i++) begin
        obank_d[i] = (4'(i) < fill) ? coll_d[i] : '0;
        coll_d[i]  = '0;
      end
      idx_d = 3'd0;
      ov_d  = 1'b1;
      cnt_d = cnt_q + {{(GRP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      if (accept) idx_d = idx_q + 3'd1;
      if (ov_q && out_ready) ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        coll_q[i]  <= '0;
        obank_q[i] <= '0;
      end
      idx_q <= 3'd0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      coll_q  <= coll_d;
      obank_q <= obank_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign isum0_0_0_0 = obank_q[0];
  assign isum0_0_0_1 = obank_q[1];
  assign isum0_0_1_0 = obank_q[2];
  assign isum0_0_1_1 = obank_q[3];
  assign isum0_1_0_0 = obank_q[4];
  assign isum0_1_0_1 = obank_q[5];
  assign isum0_1_1_0 = obank_q[6];
  assign isum0_1_1_1 = obank_q[7];
  assign out_valid   = ov_q;
  assign grp_count   = cnt_q;

endmodule
